// File: rtl/phase_cycle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : phase_cycle_pkg
//  Brief    : Shared types and constants for the phase-cycling scheduler.
//             Optional readback port is enabled with PHASE_CYCLE_READBACK_EN.
//  Revision : 1.0  initial release
// ============================================================================
package phase_cycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_ACQ     = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] PH_0   = 2'd0;
    localparam logic [1:0] PH_90  = 2'd1;
    localparam logic [1:0] PH_180 = 2'd2;
    localparam logic [1:0] PH_270 = 2'd3;

    localparam int TX_LSB = 2;
    localparam int RX_LSB = 0;

    // Pack a (tx, rx) phase pair into a table word.
    function automatic logic [3:0] tbl_entry(input logic [1:0] tx, input logic [1:0] rx);
        return {tx, rx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : phase_cycle_if
//  Brief    : Control/status bundle between the host side and the scheduler.
//             PHASE_CYCLE_READBACK_EN adds the table readback signals.
//  Revision : 1.0  initial release
// ============================================================================
interface phase_cycle_if #(
    parameter int TBL_DEPTH = 16,
    parameter int SCAN_W    = 16
);
    localparam int AW = $clog2(TBL_DEPTH);

    logic              tbl_wr_en;
    logic [AW-1:0]     tbl_wr_addr;
    logic [3:0]        tbl_wr_data;
    logic [AW:0]       cycle_len;
    logic [SCAN_W-1:0] n_scans;
    logic              start;
    logic              abort;
    logic              scan_trig;
    logic              acq_done;
    logic [1:0]        tx_phase;
    logic [1:0]        rx_phase;
    logic              acq_en;
    logic              busy;
    logic              run_done;
    logic [SCAN_W-1:0] scan_cnt;
    logic              overrun;
`ifdef PHASE_CYCLE_READBACK_EN
    logic [AW-1:0]     tbl_rd_addr;
    logic [3:0]        tbl_rd_data;
`endif

    modport master (
`ifdef PHASE_CYCLE_READBACK_EN
        output tbl_rd_addr,
        input  tbl_rd_data,
`endif
        output tbl_wr_en, tbl_wr_addr, tbl_wr_data, cycle_len, n_scans,
        output start, abort, scan_trig, acq_done,
        input  tx_phase, rx_phase, acq_en, busy, run_done, scan_cnt, overrun
    );

    modport slave (
`ifdef PHASE_CYCLE_READBACK_EN
        input  tbl_rd_addr,
        output tbl_rd_data,
`endif
        input  tbl_wr_en, tbl_wr_addr, tbl_wr_data, cycle_len, n_scans,
        input  start, abort, scan_trig, acq_done,
        output tx_phase, rx_phase, acq_en, busy, run_done, scan_cnt, overrun
    );

endinterface
`default_nettype wire

// File: rtl/phase_cycle_table.sv
`default_nettype none
// ============================================================================
//  Module   : phase_cycle_table
//  Brief    : TBL_DEPTH x 4 phase table, synchronous read. The main read
//             register only loads on i_rd_en so it doubles as the phase hold
//             register. PHASE_CYCLE_READBACK_EN adds a free-running 2nd port.
//  Revision : 1.0  initial release
// ============================================================================
module phase_cycle_table #(
    parameter int TBL_DEPTH = 16,
    parameter int AW        = $clog2(TBL_DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_wr_en,
    input  wire logic [AW-1:0] i_wr_addr,
    input  wire logic [3:0]    i_wr_data,
    input  wire logic          i_rd_en,
    input  wire logic [AW-1:0] i_rd_addr,
`ifdef PHASE_CYCLE_READBACK_EN
    input  wire logic [AW-1:0] i_rd2_addr,
    output logic [3:0]         o_rd2_data,
`endif
    output logic [3:0]         o_rd_data
);

    logic [3:0] r_mem [TBL_DEPTH];
    logic [3:0] r_rd_data;

    // Table storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // Scheduler read port: output holds until the next enabled read.
    always_ff @(posedge clk) begin
        if (rst)          r_rd_data <= 4'd0;
        else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

`ifdef PHASE_CYCLE_READBACK_EN
    logic [3:0] r_rd2_data;

    // Host readback port, one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) r_rd2_data <= 4'd0;
        else     r_rd2_data <= r_mem[i_rd2_addr];
    end

    assign o_rd2_data = r_rd2_data;
`endif

endmodule
`default_nettype wire

// File: rtl/phase_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : phase_cycle_ctrl
//  Brief    : Scan-by-scan phase-cycling scheduler. Steps a (tx,rx) phase
//             table once per scan, gates acquisition against scan_trig and
//             counts scans. PHASE_CYCLE_READBACK_EN adds table readback.
//  Revision : 1.0  initial release
// ============================================================================
module phase_cycle_ctrl
    import phase_cycle_pkg::*;
#(
    parameter int TBL_DEPTH = 16,
    parameter int SCAN_W    = 16
) (
    input wire logic    clk,
    input wire logic    rst,
    phase_cycle_if.slave bus
);

    localparam int AW = $clog2(TBL_DEPTH);
    localparam logic [AW:0]       c_idx_one = {{AW{1'b0}}, 1'b1};
    localparam logic [SCAN_W-1:0] c_cnt_one = {{(SCAN_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_start_ok;
    logic              w_overrun_set;
    logic              w_busy;
    logic [AW:0]       r_cycle_len;
    logic [SCAN_W-1:0] r_n_scans;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [AW-1:0]     r_index;
    logic              r_acq_en;
    logic              r_run_done;
    logic              r_overrun;
    logic [AW:0]       w_index_inc;
    logic [AW-1:0]     w_index_nxt;
    logic [SCAN_W-1:0] w_scan_cnt_inc;
    logic [3:0]        w_tbl_rd_data;

    assign w_busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_index_inc    = {1'b0, r_index} + c_idx_one;
    assign w_index_nxt    = (w_index_inc == r_cycle_len) ? '0 : w_index_inc[AW-1:0];
    assign w_scan_cnt_inc = r_scan_cnt + c_cnt_one;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides every transition out of a busy state.
    always_comb begin
        w_state_nxt   = r_state;
        w_start_ok    = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = (bus.n_scans == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_overrun_set = bus.scan_trig;
                w_state_nxt   = ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.scan_trig) w_state_nxt = ST_ACQ;
            end
            ST_ACQ: begin
                w_overrun_set = bus.scan_trig;
                if (bus.acq_done) w_state_nxt = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                w_overrun_set = bus.scan_trig;
                w_state_nxt   = (w_scan_cnt_inc == r_n_scans) ? ST_DONE : ST_LOAD;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (bus.abort && w_busy) w_state_nxt = ST_IDLE;
    end

    // Run bookkeeping: latched config, table index, scan count, status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_len <= '0;
            r_n_scans   <= '0;
            r_scan_cnt  <= '0;
            r_index     <= '0;
            r_acq_en    <= 1'b0;
            r_run_done  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_acq_en   <= (w_state_nxt == ST_ACQ);
            r_run_done <= (r_state == ST_DONE);
            if (w_start_ok) begin
                r_cycle_len <= (bus.cycle_len == '0) ? c_idx_one : bus.cycle_len;
                r_n_scans   <= bus.n_scans;
                r_scan_cnt  <= '0;
                r_index     <= '0;
                r_overrun   <= 1'b0;
            end else begin
                if (w_overrun_set) r_overrun <= 1'b1;
                if (r_state == ST_ADVANCE) begin
                    r_scan_cnt <= w_scan_cnt_inc;
                    r_index    <= w_index_nxt;
                end
            end
        end
    end

    phase_cycle_table #(
        .TBL_DEPTH (TBL_DEPTH),
        .AW        (AW)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (bus.tbl_wr_en && !w_busy),
        .i_wr_addr  (bus.tbl_wr_addr),
        .i_wr_data  (bus.tbl_wr_data),
        .i_rd_en    (r_state == ST_LOAD),
        .i_rd_addr  (r_index),
`ifdef PHASE_CYCLE_READBACK_EN
        .i_rd2_addr (bus.tbl_rd_addr),
        .o_rd2_data (bus.tbl_rd_data),
`endif
        .o_rd_data  (w_tbl_rd_data)
    );

    assign bus.tx_phase = w_tbl_rd_data[TX_LSB +: 2];
    assign bus.rx_phase = w_tbl_rd_data[RX_LSB +: 2];
    assign bus.acq_en   = r_acq_en;
    assign bus.busy     = w_busy;
    assign bus.run_done = r_run_done;
    assign bus.scan_cnt = r_scan_cnt;
    assign bus.overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_phase_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_cycle_ctrl
//  Brief    : Directed, table-driven bench for phase_cycle_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_phase_cycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    phase_cycle_if #(.TBL_DEPTH(16), .SCAN_W(16)) bus ();

    phase_cycle_ctrl #(.TBL_DEPTH(16), .SCAN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  exp_tx;
        logic [1:0]  exp_rx;
        logic [15:0] exp_cnt;
        bit          last;
    } scan_vec_t;

    scan_vec_t vec [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tbl_write(input logic [3:0] addr, input logic [1:0] tx, input logic [1:0] rx);
        bus.tbl_wr_en   = 1'b1;
        bus.tbl_wr_addr = addr;
        bus.tbl_wr_data = {tx, rx};
        step();
        bus.tbl_wr_en   = 1'b0;
    endtask

    // Start a run and advance into ARMED.
    task automatic start_run(input logic [4:0] cl, input logic [15:0] ns);
        bus.cycle_len = cl;
        bus.n_scans   = ns;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_overrun_clr", bus.overrun, 0);
        step();
    endtask

    // One full scan from ARMED; ends in ARMED of next scan or after run_done.
    task automatic do_scan(input logic [1:0] etx, input logic [1:0] erx,
                           input logic [15:0] ecnt, input bit last);
        chk("armed_tx", bus.tx_phase, etx);
        chk("armed_rx", bus.rx_phase, erx);
        chk("armed_acq_en", bus.acq_en, 0);
        bus.scan_trig = 1'b1;
        step();
        bus.scan_trig = 1'b0;
        chk("acq_en_on", bus.acq_en, 1);
        step();
        chk("acq_tx_hold", bus.tx_phase, etx);
        bus.acq_done = 1'b1;
        step();
        bus.acq_done = 1'b0;
        chk("acq_en_off", bus.acq_en, 0);
        step();
        chk("scan_cnt", bus.scan_cnt, ecnt);
        chk("no_early_done", bus.run_done, 0);
        if (!last) begin
            step();
        end else begin
            chk("busy_low_done", bus.busy, 0);
            step();
            chk("run_done_pulse", bus.run_done, 1);
            step();
            chk("run_done_single", bus.run_done, 0);
        end
    endtask

    initial begin
        bus.tbl_wr_en = 0; bus.tbl_wr_addr = 0; bus.tbl_wr_data = 0;
        bus.cycle_len = 0; bus.n_scans = 0; bus.start = 0; bus.abort = 0;
        bus.scan_trig = 0; bus.acq_done = 0;
`ifdef PHASE_CYCLE_READBACK_EN
        bus.tbl_rd_addr = 0;
`endif
        step();
        step();
        rst = 1'b0;
        chk("rst_tx", bus.tx_phase, 0);
        chk("rst_rx", bus.rx_phase, 0);
        chk("rst_acq_en", bus.acq_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_run_done", bus.run_done, 0);
        chk("rst_scan_cnt", bus.scan_cnt, 0);
        chk("rst_overrun", bus.overrun, 0);

        // n_scans = 0: straight to DONE, run_done two cycles after start
        bus.n_scans = 0; bus.cycle_len = 4; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ns0_busy", bus.busy, 0);
        chk("ns0_no_done_yet", bus.run_done, 0);
        step();
        chk("ns0_run_done", bus.run_done, 1);
        chk("ns0_acq_en", bus.acq_en, 0);
        chk("ns0_tx", bus.tx_phase, 0);
        chk("ns0_rx", bus.rx_phase, 0);
        step();
        chk("ns0_done_clear", bus.run_done, 0);

        // CYCLOPS: 4-entry table, 8 scans
        for (int i = 0; i < 4; i++) tbl_write(i[3:0], i[1:0], i[1:0]);
        for (int i = 0; i < 8; i++) begin
            vec[i].exp_tx  = i[1:0];
            vec[i].exp_rx  = i[1:0];
            vec[i].exp_cnt = 16'(i + 1);
            vec[i].last    = (i == 7);
        end
        start_run(5'd4, 16'd8);
        for (int i = 0; i < 8; i++) do_scan(vec[i].exp_tx, vec[i].exp_rx, vec[i].exp_cnt, vec[i].last);
        chk("cyclops_cnt", bus.scan_cnt, 8);

        // cycle_len = 0 behaves as 1: index stays at 0
        tbl_write(4'd0, 2'd2, 2'd3);
        start_run(5'd0, 16'd3);
        for (int i = 0; i < 3; i++) do_scan(2'd2, 2'd3, 16'(i + 1), i == 2);

        // Extra scan_trig in ACQ sets sticky overrun, sequencing unaffected
        tbl_write(4'd0, 2'd0, 2'd0);
        start_run(5'd4, 16'd4);
        bus.scan_trig = 1'b1;
        step();
        step();
        chk("ovr_acq_en", bus.acq_en, 1);
        chk("ovr_set", bus.overrun, 1);
        bus.scan_trig = 1'b0;
        bus.acq_done = 1'b1;
        step();
        bus.acq_done = 1'b0;
        step();
        step();
        for (int i = 1; i < 4; i++) do_scan(i[1:0], i[1:0], 16'(i + 1), i == 3);
        chk("ovr_held", bus.overrun, 1);

        // Abort in scan 2; table write during the run must be ignored
        tbl_write(4'd4, 2'd0, 2'd2);
        tbl_write(4'd5, 2'd1, 2'd2);
        start_run(5'd8, 16'd8);
        tbl_write(4'd5, 2'd3, 2'd0);
        do_scan(2'd0, 2'd0, 16'd1, 1'b0);
        bus.scan_trig = 1'b1;
        step();
        bus.scan_trig = 1'b0;
        chk("abort_pre_acq", bus.acq_en, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_acq_en", bus.acq_en, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_cnt", bus.scan_cnt, 1);
        chk("abort_no_done0", bus.run_done, 0);
        step();
        chk("abort_no_done1", bus.run_done, 0);

        // Later run through index 5 with wrap at cycle_len = 6
        vec[0] = '{2'd0, 2'd0, 16'd1, 1'b0};
        vec[1] = '{2'd1, 2'd1, 16'd2, 1'b0};
        vec[2] = '{2'd2, 2'd2, 16'd3, 1'b0};
        vec[3] = '{2'd3, 2'd3, 16'd4, 1'b0};
        vec[4] = '{2'd0, 2'd2, 16'd5, 1'b0};
        vec[5] = '{2'd1, 2'd2, 16'd6, 1'b0};
        vec[6] = '{2'd0, 2'd0, 16'd7, 1'b1};
        start_run(5'd6, 16'd7);
        for (int i = 0; i < 7; i++) do_scan(vec[i].exp_tx, vec[i].exp_rx, vec[i].exp_cnt, vec[i].last);

        // rst in ARMED, then restart from index 0
        tbl_write(4'd0, 2'd2, 2'd1);
        start_run(5'd4, 16'd4);
        do_scan(2'd2, 2'd1, 16'd1, 1'b0);
        chk("pre_rst_tx", bus.tx_phase, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_tx", bus.tx_phase, 0);
        chk("mid_rst_rx", bus.rx_phase, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_cnt", bus.scan_cnt, 0);
        chk("mid_rst_acq_en", bus.acq_en, 0);
        start_run(5'd4, 16'd1);
        bus.acq_done = 1'b1;
        step();
        bus.acq_done = 1'b0;
        chk("stray_done_acq_en", bus.acq_en, 0);
        chk("stray_done_busy", bus.busy, 1);
        chk("stray_done_cnt", bus.scan_cnt, 0);
        do_scan(2'd2, 2'd1, 16'd1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
